// File: rtl/rr_burst_arbiter_pkg.sv
// rr_burst_arbiter_pkg: shared state encoding and grant-id width for the burst arbiter
package rr_burst_arbiter_pkg;
   localparam int GID_W = 4;
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// rr_pick: rotating-priority pick of the first set request at or after start
module rr_pick
   import rr_burst_arbiter_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]     req,
   input  logic [GID_W-1:0] start,
   output logic [N-1:0]     onehot,
   output logic [GID_W-1:0] idx,
   output logic             any
);
   int best;
   assign any = |req;
   // smallest rotated distance from start wins
   always_comb begin
      best = N;
      idx = '0;
      onehot = '0;
      for (int c = 0; c < N; c++) begin
         if (req[c] && ((c + N - int'(start)) % N) < best) begin
            best = (c + N - int'(start)) % N;
            idx = GID_W'(c);
         end
      end
      for (int c = 0; c < N; c++)
         onehot[c] = req[c] && idx == GID_W'(c);
   end
endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin arbiter with burst/hold locking, registered output stage
// and saturating per-channel word counters.
module rr_burst_arbiter
   import rr_burst_arbiter_pkg::*;
#(
   parameter int WIDTH      = 2,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [WIDTH-1:0]            WRITE_REQ,
   input  logic [WIDTH-1:0]            HOLD_REQ,
   input  logic [WIDTH-1:0]            CH_ENABLE,
   input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
   output logic [WIDTH-1:0]            READ_GRANT,
   input  logic                        READY_IN,
   output logic                        WRITE_OUT,
   output logic [DATA_WIDTH-1:0]       DATA_OUT,
   output logic [GID_W-1:0]            GRANT_ID,
   output logic [WIDTH*CNT_WIDTH-1:0]  WORD_CNT
);
   state_t                state, state_n;
   logic [WIDTH-1:0]      eligible, lock_oh, lock_oh_n, pick_oh, sel_oh;
   logic [GID_W-1:0]      lock_id, lock_id_n, last_grant, last_n, start, pick_id, sel_id;
   logic [7:0]            bcnt, bcnt_n;
   logic                  pick_any, load_en, lk, grant;
   logic [DATA_WIDTH-1:0] sel_data;

   assign load_en  = !WRITE_OUT || READY_IN;
   assign eligible = WRITE_REQ & CH_ENABLE;
   assign start    = (last_grant >= GID_W'(WIDTH - 1)) ? '0 : last_grant + 1'b1;
   // lock stays effective only while the channel is eligible and its burst/hold allows more
   assign lk = state == LOCKED && |(eligible & lock_oh) &&
               (|(HOLD_REQ & lock_oh) || bcnt < 8'(BURST_LEN));
   assign sel_oh     = lk ? lock_oh : pick_oh;
   assign sel_id     = lk ? lock_id : pick_id;
   assign grant      = !RST && load_en && (lk || pick_any);
   assign READ_GRANT = grant ? sel_oh : '0;

   rr_pick #(.N(WIDTH)) u_pick (
      .req   (eligible),
      .start (start),
      .onehot(pick_oh),
      .idx   (pick_id),
      .any   (pick_any)
   );

   always_comb begin
      sel_data = '0;
      for (int c = 0; c < WIDTH; c++)
         if (sel_oh[c]) sel_data = DATA_IN[c*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      state_n   = lk ? LOCKED : IDLE;
      lock_oh_n = lock_oh;
      lock_id_n = lock_id;
      bcnt_n    = bcnt;
      last_n    = last_grant;
      if (grant) begin
         last_n = sel_id;
         if (lk) begin
            bcnt_n = (bcnt == 8'hFF) ? bcnt : bcnt + 8'd1;
         end else begin
            state_n   = (|(HOLD_REQ & pick_oh) || BURST_LEN > 1) ? LOCKED : IDLE;
            lock_oh_n = pick_oh;
            lock_id_n = pick_id;
            bcnt_n    = 8'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         lock_oh    <= '0;
         lock_id    <= '0;
         bcnt       <= '0;
         last_grant <= GID_W'(WIDTH - 1);
      end else begin
         state      <= state_n;
         lock_oh    <= lock_oh_n;
         lock_id    <= lock_id_n;
         bcnt       <= bcnt_n;
         last_grant <= last_n;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         WRITE_OUT <= 1'b0;
         DATA_OUT  <= '0;
         GRANT_ID  <= '0;
      end else if (load_en) begin
         WRITE_OUT <= grant;
         if (grant) begin
            DATA_OUT <= sel_data;
            GRANT_ID <= sel_id;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         WORD_CNT <= '0;
      end else if (WRITE_OUT && READY_IN) begin
         for (int c = 0; c < WIDTH; c++)
            if (GRANT_ID == GID_W'(c) && WORD_CNT[c*CNT_WIDTH +: CNT_WIDTH] != '1)
               WORD_CNT[c*CNT_WIDTH +: CNT_WIDTH] <= WORD_CNT[c*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
   end
endmodule

// File: doc/rr_burst_arbiter.md
RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of source channels, legal range 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of each channel's data word.
REQ-003 SHALL have parameter BURST_LEN, default 1: maximum words per non-held grant, legal range 1..255.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of each per-channel word counter.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port WRITE_REQ, input, WIDTH bits: channel i has a valid word on DATA_IN (first-word-fall-through source).
REQ-008 SHALL have port HOLD_REQ, input, WIDTH bits: channel i requests that its grant be kept (multi-word event).
REQ-009 SHALL have port CH_ENABLE, input, WIDTH bits: channel i may be granted.
REQ-010 SHALL have port DATA_IN, input, WIDTH*DATA_WIDTH bits: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port READ_GRANT, output, WIDTH bits: one-hot pop strobe to channel i.
REQ-012 SHALL have port READY_IN, input, 1 bit: downstream accepts DATA_OUT this cycle.
REQ-013 SHALL have port WRITE_OUT, output, 1 bit: DATA_OUT valid.
REQ-014 SHALL have port DATA_OUT, output, DATA_WIDTH bits: the registered output word.
REQ-015 SHALL have port GRANT_ID, output, 4 bits: channel index of the word currently on DATA_OUT.
REQ-016 SHALL have port WORD_CNT, output, WIDTH*CNT_WIDTH bits: per-channel count of words transferred.

Function
REQ-017 SHALL compute load_en = !WRITE_OUT || READY_IN; a downstream transfer occurs when WRITE_OUT && READY_IN.
REQ-018 SHALL compute eligible = WRITE_REQ & CH_ENABLE.
REQ-019 SHALL, in state IDLE, select the first eligible channel in round-robin order starting at last_grant+1 (modulo WIDTH).
REQ-020 SHALL, in state LOCKED, select the locked channel only.
REQ-021 SHALL, on any cycle with load_en high and the selected channel eligible, assert READ_GRANT for that channel only (combinational, same cycle).
REQ-022 SHALL, on that cycle's clock edge, register DATA_OUT and GRANT_ID from the granted channel and set WRITE_OUT high (1-cycle latency, full throughput).
REQ-023 SHALL clear WRITE_OUT when load_en is high and no grant occurs.
REQ-024 SHALL hold DATA_OUT, GRANT_ID and WRITE_OUT stable while WRITE_OUT && !READY_IN, with READ_GRANT held at 0.
REQ-025 SHALL transition IDLE->LOCKED on a grant when HOLD_REQ[ch] is high or BURST_LEN > 1, storing ch and setting burst_cnt = 1.
REQ-026 SHALL, in LOCKED, increment burst_cnt on each grant (8-bit counter).
REQ-027 SHALL exit LOCKED->IDLE when any of the following holds: the locked channel is no longer eligible; or HOLD_REQ is low and burst_cnt has reached BURST_LEN; or a cycle passes with load_en high and no grant.
REQ-028 SHALL not limit a held lock (HOLD_REQ high) by BURST_LEN.
REQ-029 SHALL update last_grant to the channel of every grant.
REQ-030 SHALL, if CH_ENABLE of the locked channel drops, issue no further grant to that channel from the next cycle, and SHALL leave an already registered word to complete normally.
REQ-031 SHALL increment WORD_CNT[i] on each downstream transfer with GRANT_ID = i, saturating at all-ones with no wrap.
REQ-032 SHALL, with WIDTH = 1, degenerate to a registered pass-through with hold and counter behaviour intact.

Reset
REQ-033 SHALL, while RST is high at a clock edge, drive the following to 0: WRITE_OUT, DATA_OUT, GRANT_ID, WORD_CNT, burst_cnt and READ_GRANT.
REQ-034 SHALL, while RST is high, force state to IDLE and last_grant to WIDTH-1, so that channel 0 has first priority after reset.
REQ-035 SHALL, on reset asserted mid-transfer, discard the registered word without a transfer or count update.

Structure
REQ-036 SHALL place the state encoding (IDLE = 0, LOCKED = 1) and the GRANT_ID width constant in the shared arbiter include/package.
REQ-037 SHALL implement the rotating priority pick as one combinational sub-module rr_pick (inputs: request vector, start index; outputs: one-hot, index, any).

Verification
REQ-038 SHALL verify: WIDTH = 4, all WRITE_REQ and CH_ENABLE high, READY_IN = 1 -> GRANT_ID sequence 0,1,2,3,0, one word per cycle.
REQ-039 SHALL verify: ch1 HOLD_REQ high for 5 words while ch0 and ch2 request -> 5 consecutive ch1 words, then ch2, then ch0.
REQ-040 SHALL verify: BURST_LEN = 3, ch0 and ch1 continuously requesting -> ID pattern 0,0,0,1,1,1.
REQ-041 SHALL verify: READY_IN low for 4 cycles mid-stream -> DATA_OUT stable, READ_GRANT = 0, and no word lost or duplicated after release.
REQ-042 SHALL verify: CH_ENABLE[2] dropped while ch2 is locked -> next grant goes to another channel and the ch2 count equals the words actually transferred.
REQ-043 SHALL verify: CNT_WIDTH = 4 with 20 ch0 transfers -> WORD_CNT[0] = 15; RST pulse mid-stream -> WRITE_OUT = 0 and all counts = 0 on the next cycle.
